// File: rtl/vme_reg_bank_if.sv
// VME slave-side register access bus: word address, write data, request strobes and acknowledges.
// Master drives the request fields. Slave returns read data and the per-transaction done pulses.
interface vme_reg_bank_if #(
    parameter int ADDR_W = 2
);
    logic [ADDR_W+1:2] VMEAddr;
    logic [31:0]       VMEWrData;
    logic              VMERdMem;
    logic              VMEWrMem;
    logic [31:0]       VMERdData;
    logic              VMERdDone;
    logic              VMEWrDone;

    modport master (
        output VMEAddr, VMEWrData, VMERdMem, VMEWrMem,
        input  VMERdData, VMERdDone, VMEWrDone
    );

    modport slave (
        input  VMEAddr, VMEWrData, VMERdMem, VMEWrMem,
        output VMERdData, VMERdDone, VMEWrDone
    );
endinterface

// File: rtl/vme_reg_bank.sv
// Parametrised VME control/status register bank (R/W registers to fabric, RO registers from fabric).
// Latency: write ack 1 cycle, register/strobe 1 edge later; read 1 cycle (2 with VME_REG_BANK_RDPIPE_EN).
// Backpressure: none; a request is accepted on every cycle it is high.
module vme_reg_bank #(
    parameter int                            NUM_REGS    = 4,
    parameter int                            ADDR_W      = 2,
    parameter int                            REG_WIDTH   = 32,
    parameter logic [NUM_REGS-1:0]           RO_MASK     = '0,
    parameter logic [NUM_REGS*REG_WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic                          Clk,
    input  logic                          Rst,
    vme_reg_bank_if.slave                 vme,
    output logic [NUM_REGS*REG_WIDTH-1:0] regs_o,
    input  logic [NUM_REGS*REG_WIDTH-1:0] status_i,
    output logic [NUM_REGS-1:0]           wr_strobe_o
);

    logic                          wr_req_d0;
    logic [ADDR_W-1:0]             wr_adr_d0;
    logic [REG_WIDTH-1:0]          wr_dat_d0;
    logic [NUM_REGS*REG_WIDTH-1:0] regs_q;
    logic [NUM_REGS-1:0]           wr_strobe_q;
    logic [31:0]                   rd_val;
    logic [31:0]                   rd_dat_q;
    logic                          rd_done_q;

    always_ff @(posedge Clk) begin
        if (Rst) begin
            wr_req_d0 <= 1'b0;
            wr_adr_d0 <= '0;
            wr_dat_d0 <= '0;
        end else begin
            wr_req_d0 <= vme.VMEWrMem;
            wr_adr_d0 <= vme.VMEAddr;
            wr_dat_d0 <= vme.VMEWrData[REG_WIDTH-1:0];
        end
    end

    // RO slots hold constant zero so regs_o reports 0 for them; their flops trim away.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            for (int i = 0; i < NUM_REGS; i++)
                regs_q[i*REG_WIDTH +: REG_WIDTH] <= RO_MASK[i] ? '0 : RESET_VALUE[i*REG_WIDTH +: REG_WIDTH];
        end else begin
            for (int i = 0; i < NUM_REGS; i++)
                if (wr_req_d0 && (wr_adr_d0 == ADDR_W'(i)) && !RO_MASK[i])
                    regs_q[i*REG_WIDTH +: REG_WIDTH] <= wr_dat_d0;
        end
    end

    // RO entries still strobe so software can use a write as a trigger.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            wr_strobe_q <= '0;
        end else begin
            for (int i = 0; i < NUM_REGS; i++)
                wr_strobe_q[i] <= wr_req_d0 && (wr_adr_d0 == ADDR_W'(i));
        end
    end

    always_comb begin
        rd_val = '0;
        for (int i = 0; i < NUM_REGS; i++)
            if (vme.VMEAddr == ADDR_W'(i))
                rd_val[REG_WIDTH-1:0] = RO_MASK[i] ? status_i[i*REG_WIDTH +: REG_WIDTH]
                                                   : regs_q[i*REG_WIDTH +: REG_WIDTH];
    end

    // Read samples regs_q before a same-cycle write lands, giving pre-write data on collision.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            rd_done_q <= 1'b0;
            rd_dat_q  <= '0;
        end else begin
            rd_done_q <= vme.VMERdMem;
            if (vme.VMERdMem)
                rd_dat_q <= rd_val;
        end
    end

`ifdef VME_REG_BANK_RDPIPE_EN
    logic [31:0] rd_dat_p;
    logic        rd_done_p;

    always_ff @(posedge Clk) begin
        if (Rst) begin
            rd_done_p <= 1'b0;
            rd_dat_p  <= '0;
        end else begin
            rd_done_p <= rd_done_q;
            if (rd_done_q)
                rd_dat_p <= rd_dat_q;
        end
    end

    assign vme.VMERdData = rd_dat_p;
    assign vme.VMERdDone = rd_done_p & ~Rst;
`else
    assign vme.VMERdData = rd_dat_q;
    assign vme.VMERdDone = rd_done_q & ~Rst;
`endif

    // Acks are masked while Rst is high so an interrupted transaction never completes.
    assign vme.VMEWrDone = wr_req_d0 & ~Rst;
    assign wr_strobe_o   = wr_strobe_q & {NUM_REGS{~Rst}};
    assign regs_o        = regs_q;

endmodule

// File: tb/tb_vme_reg_bank.sv
// Scoreboard bench for vme_reg_bank: three configurations (32-bit, 11-bit with RO reg 3, 3 regs with hole).
// Driver queues expected reads/strobes; a negedge monitor pops and compares on every Done/strobe.
module tb_vme_reg_bank;

`ifdef VME_REG_BANK_RDPIPE_EN
    localparam int RD_LAT = 2;
`else
    localparam int RD_LAT = 1;
`endif

    localparam logic [127:0] RV_A = {32'd0, 32'd0, 32'hA5A5_0001, 32'd0};

    typedef struct { int d; logic [31:0] dat; int cyc; } rd_exp_t;
    typedef struct { int d; logic [3:0] stb; } stb_exp_t;

    logic Clk = 1'b0;
    logic Rst = 1'b1;
    always #5 Clk = ~Clk;

    int cyc = 0;
    always @(posedge Clk) cyc <= cyc + 1;

    logic [1:0]  d_adr  [3];
    logic [31:0] d_wdat [3];
    logic        d_rd   [3];
    logic        d_wr   [3];

    vme_reg_bank_if #(.ADDR_W(2)) if_a ();
    vme_reg_bank_if #(.ADDR_W(2)) if_b ();
    vme_reg_bank_if #(.ADDR_W(2)) if_c ();

    assign if_a.VMEAddr = d_adr[0];  assign if_a.VMEWrData = d_wdat[0];
    assign if_a.VMERdMem = d_rd[0];  assign if_a.VMEWrMem  = d_wr[0];
    assign if_b.VMEAddr = d_adr[1];  assign if_b.VMEWrData = d_wdat[1];
    assign if_b.VMERdMem = d_rd[1];  assign if_b.VMEWrMem  = d_wr[1];
    assign if_c.VMEAddr = d_adr[2];  assign if_c.VMEWrData = d_wdat[2];
    assign if_c.VMERdMem = d_rd[2];  assign if_c.VMEWrMem  = d_wr[2];

    logic [127:0] regs_a, status_a;
    logic [43:0]  regs_b, status_b;
    logic [95:0]  regs_c, status_c;
    logic [3:0]   stb_a, stb_b;
    logic [2:0]   stb_c;

    assign status_a = '0;
    assign status_b = {11'h155, 33'h0};
    assign status_c = '0;

    vme_reg_bank #(.NUM_REGS(4), .ADDR_W(2), .REG_WIDTH(32), .RO_MASK(4'b0000), .RESET_VALUE(RV_A)) dut_a (
        .Clk(Clk), .Rst(Rst), .vme(if_a), .regs_o(regs_a), .status_i(status_a), .wr_strobe_o(stb_a));
    vme_reg_bank #(.NUM_REGS(4), .ADDR_W(2), .REG_WIDTH(11), .RO_MASK(4'b1000), .RESET_VALUE(44'd0)) dut_b (
        .Clk(Clk), .Rst(Rst), .vme(if_b), .regs_o(regs_b), .status_i(status_b), .wr_strobe_o(stb_b));
    vme_reg_bank #(.NUM_REGS(3), .ADDR_W(2), .REG_WIDTH(32), .RO_MASK(3'b000), .RESET_VALUE(96'd0)) dut_c (
        .Clk(Clk), .Rst(Rst), .vme(if_c), .regs_o(regs_c), .status_i(status_c), .wr_strobe_o(stb_c));

    logic [31:0] obs_rdat  [3];
    logic        obs_rdone [3];
    logic        obs_wdone [3];
    logic [3:0]  obs_stb   [3];

    assign obs_rdat[0] = if_a.VMERdData; assign obs_rdone[0] = if_a.VMERdDone; assign obs_wdone[0] = if_a.VMEWrDone;
    assign obs_rdat[1] = if_b.VMERdData; assign obs_rdone[1] = if_b.VMERdDone; assign obs_wdone[1] = if_b.VMEWrDone;
    assign obs_rdat[2] = if_c.VMERdData; assign obs_rdone[2] = if_c.VMERdDone; assign obs_wdone[2] = if_c.VMEWrDone;
    assign obs_stb[0] = stb_a;
    assign obs_stb[1] = stb_b;
    assign obs_stb[2] = {1'b0, stb_c};

    rd_exp_t  exp_rd  [$];
    stb_exp_t exp_stb [$];
    int exp_wd [3] = '{0, 0, 0};
    int wd_cnt [3] = '{0, 0, 0};
    logic prev_wd [3] = '{1'b0, 1'b0, 1'b0};
    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Monitor: every Done/strobe must match the head of its queue.
    always @(negedge Clk) begin
        rd_exp_t  re;
        stb_exp_t se;
        for (int d = 0; d < 3; d++) begin
            if (obs_wdone[d]) wd_cnt[d]++;
            if (obs_rdone[d]) begin
                if (exp_rd.size() == 0) begin
                    n_cmp++; n_bad++;
                    $display("FAIL rd_unexpected: dut %0d data %h with nothing pending", d, obs_rdat[d]);
                end else begin
                    re = exp_rd.pop_front();
                    chk("rd_dut", 32'(d), 32'(re.d));
                    chk("rd_dat", obs_rdat[d], re.dat);
                    chk("rd_lat", 32'(cyc), 32'(re.cyc));
                end
            end
            if (obs_stb[d] != 4'b0) begin
                if (exp_stb.size() == 0) begin
                    n_cmp++; n_bad++;
                    $display("FAIL stb_unexpected: dut %0d strobe %b with nothing pending", d, obs_stb[d]);
                end else begin
                    se = exp_stb.pop_front();
                    chk("stb_dut", 32'(d), 32'(se.d));
                    chk("stb_val", 32'(obs_stb[d]), 32'(se.stb));
                    chk("stb_after_wdone", 32'(prev_wd[d]), 32'd1);
                end
            end
            prev_wd[d] = obs_wdone[d];
        end
    end

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic idle(input int d);
        d_rd[d] = 1'b0;
        d_wr[d] = 1'b0;
    endtask

    task automatic issue(input int d, input bit rd, input bit wr, input logic [1:0] adr,
                         input logic [31:0] wdat, input logic [31:0] rexp, input logic [3:0] sexp);
        rd_exp_t  re;
        stb_exp_t se;
        d_rd[d] = rd; d_wr[d] = wr; d_adr[d] = adr; d_wdat[d] = wdat;
        if (rd) begin
            re = '{d, rexp, cyc + RD_LAT};
            exp_rd.push_back(re);
        end
        if (wr) begin
            exp_wd[d]++;
            if (sexp != 4'b0) begin
                se = '{d, sexp};
                exp_stb.push_back(se);
            end
        end
    endtask

    task automatic wr_one(input int d, input logic [1:0] adr, input logic [31:0] dat, input logic [3:0] sexp);
        issue(d, 1'b0, 1'b1, adr, dat, 32'd0, sexp);
        step(); idle(d); step();
    endtask

    task automatic rd_one(input int d, input logic [1:0] adr, input logic [31:0] rexp);
        issue(d, 1'b1, 1'b0, adr, 32'd0, rexp, 4'b0);
        step(); idle(d); step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int d = 0; d < 3; d++) begin
            d_adr[d] = '0; d_wdat[d] = '0; d_rd[d] = 1'b0; d_wr[d] = 1'b0;
        end
        Rst = 1'b1;
        repeat (3) @(posedge Clk);
        @(negedge Clk);
        chk("rst_reg1", regs_a[63:32], 32'hA5A5_0001);
        chk("rst_reg0", regs_a[31:0], 32'h0);
        chk("rst_rddata", obs_rdat[0], 32'h0);
        chk("rst_dones", {29'd0, obs_rdone[0], obs_wdone[0], obs_rdone[1] | obs_wdone[1] | obs_rdone[2] | obs_wdone[2]}, 32'd0);
        chk("rst_stb", {20'd0, obs_stb[0], obs_stb[1], obs_stb[2]}, 32'd0);
        @(posedge Clk); #1;
        Rst = 1'b0;
        step();

        // Write/readback on the 32-bit bank
        wr_one(0, 2'd2, 32'hDEAD_BEEF, 4'b0100);
        rd_one(0, 2'd2, 32'hDEAD_BEEF);
        rd_one(0, 2'd1, 32'hA5A5_0001);
        repeat (3) step();
        chk("a_regs2", regs_a[95:64], 32'hDEAD_BEEF);
        chk("a_wdone_cnt1", 32'(wd_cnt[0]), 32'(exp_wd[0]));

        // Narrow registers and a read-only status register
        wr_one(1, 2'd0, 32'hFFFF_FFFF, 4'b0001);
        rd_one(1, 2'd0, 32'h0000_07FF);
        wr_one(1, 2'd3, 32'h0, 4'b1000);
        rd_one(1, 2'd3, 32'h0000_0155);
        repeat (3) step();
        chk("b_reg0", 32'(regs_b[10:0]), 32'h7FF);
        chk("b_reg3_ro_zero", 32'(regs_b[43:33]), 32'h0);
        chk("b_wdone_cnt", 32'(wd_cnt[1]), 32'(exp_wd[1]));

        // Unmapped entry in a three-register bank
        wr_one(2, 2'd0, 32'h0000_0011, 4'b0001);
        wr_one(2, 2'd3, 32'h0000_1234, 4'b0000);
        rd_one(2, 2'd3, 32'h0);
        rd_one(2, 2'd0, 32'h0000_0011);
        repeat (3) step();
        chk("c_reg0", regs_c[31:0], 32'h11);
        chk("c_reg1", regs_c[63:32], 32'h0);
        chk("c_reg2", regs_c[95:64], 32'h0);
        chk("c_wdone_cnt", 32'(wd_cnt[2]), 32'(exp_wd[2]));

        // Same-cycle read/write collision returns pre-write value
        wr_one(0, 2'd1, 32'd5, 4'b0010);
        issue(0, 1'b1, 1'b1, 2'd1, 32'd9, 32'd5, 4'b0010);
        step(); idle(0); step();
        rd_one(0, 2'd1, 32'd9);

        // Write request held four cycles, then back-to-back reads
        for (int v = 1; v <= 4; v++) begin
            issue(0, 1'b0, 1'b1, 2'd0, 32'(v), 32'd0, 4'b0001);
            step();
        end
        idle(0); step();
        issue(0, 1'b1, 1'b0, 2'd0, 32'd0, 32'd4, 4'b0); step();
        issue(0, 1'b1, 1'b0, 2'd1, 32'd0, 32'd9, 4'b0); step();
        issue(0, 1'b1, 1'b0, 2'd2, 32'd0, 32'hDEAD_BEEF, 4'b0); step();
        idle(0);
        repeat (4) step();
        chk("a_wdone_cnt2", 32'(wd_cnt[0]), 32'(exp_wd[0]));
        chk("a_reg0_last", regs_a[31:0], 32'd4);

        // Reset asserted while a write is in flight
        d_adr[0] = 2'd1; d_wdat[0] = 32'h77; d_wr[0] = 1'b1;
        step();
        Rst = 1'b1; d_wr[0] = 1'b0;
        step();
        Rst = 1'b0;
        repeat (3) step();
        chk("rstmid_wdone", 32'(wd_cnt[0]), 32'(exp_wd[0]));
        chk("rstmid_reg1", regs_a[63:32], 32'hA5A5_0001);
        chk("rstmid_reg2", regs_a[95:64], 32'h0);

        repeat (3) step();
        chk("rd_queue_drained", 32'(exp_rd.size()), 32'd0);
        chk("stb_queue_drained", 32'(exp_stb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
